// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer in front of data_mem.
// Optional misaligned-access rejection under `DMEM_ARB_MISALIGN_CHECK_EN.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   a_req/a_we/a_nb/a_addr/a_wdata    requester A (pipeline MEM stage)
//   a_gnt/a_rvalid/a_rdata/a_err      A grant pulse, completion pulse, data, reject
//   b_*                               same set for requester B (loader/DMA/debug)
//   mem_rd/mem_wr/mem_nb/mem_addr     data_mem strobes, size code, address
//   mem_wdata/mem_rdata               data_mem write and read data
//   busy                              sequencer not idle
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int ACC_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [2:0]    a_nb,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [2:0]    b_nb,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [2:0]    mem_nb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          rd_d, wr_d;
  logic [2:0]    nb_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          a_gnt_d, b_gnt_d;
  logic          a_rv_d, b_rv_d;
  logic          a_err_d, b_err_d;
  logic [DW-1:0] a_rdata_d, b_rdata_d;
  logic [DW-1:0] resp_data;
  logic          win_b;
  logic          bad;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  function automatic logic misaligned(
    input logic [2:0] nb,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b1;
    case (nb)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = lo[0];
      3'b010:         m = |lo;
      default:        m = 1'b1;
    endcase
    return m;
  endfunction
`endif

  // Load data is taken at the last ACCESS edge; stores
  // and rejected requests return zero.
  assign resp_data = (we_q || err_q) ? '0 : mem_rdata;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    we_d      = we_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    nb_d      = mem_nb;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_rv_d    = 1'b0;
    b_rv_d    = 1'b0;
    a_err_d   = 1'b0;
    b_err_d   = 1'b0;
    a_rdata_d = '0;
    b_rdata_d = '0;
    win_b     = 1'b0;
    bad       = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          win_b   = b_req && (!a_req || rr_q);
          sel_d   = win_b;
          rr_d    = ~win_b;
          we_d    = win_b ? b_we    : a_we;
          nb_d    = win_b ? b_nb    : a_nb;
          addr_d  = win_b ? b_addr  : a_addr;
          wdata_d = win_b ? b_wdata : a_wdata;
          a_gnt_d = ~win_b;
          b_gnt_d = win_b;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
          bad = misaligned(nb_d, addr_d[1:0]);
`endif
          err_d   = bad;
          state_d = ACCESS;
          // A rejected request spends a single
          // strobe-free cycle here before RESP.
          cnt_d   = bad ? '0 : CW'(ACC_CYC - 1);
          rd_d    = ~bad & ~we_d;
          wr_d    = ~bad & we_d;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          rd_d  = ~err_q & ~we_q;
          wr_d  = ~err_q & we_q;
        end else begin
          state_d = RESP;
          if (sel_q) begin
            b_rv_d    = 1'b1;
            b_err_d   = err_q;
            b_rdata_d = resp_data;
          end else begin
            a_rv_d    = 1'b1;
            a_err_d   = err_q;
            a_rdata_d = resp_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_nb    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      mem_rd    <= rd_d;
      mem_wr    <= wr_d;
      mem_nb    <= nb_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      a_gnt     <= a_gnt_d;
      b_gnt     <= b_gnt_d;
      a_rvalid  <= a_rv_d;
      b_rvalid  <= b_rv_d;
      a_err     <= a_err_d;
      b_err     <= b_err_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter.
// u0 runs ACC_CYC=1 against a word memory model; u3 runs ACC_CYC=3.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ACC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [2:0]    a_nb, b_nb;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, a_err;
  logic          b_gnt, b_rvalid, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_rd, mem_wr, busy;
  logic [2:0]    mem_nb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          rst_n_3;
  logic          a_req_3, a_we_3, b_req_3, b_we_3;
  logic [2:0]    a_nb_3, b_nb_3;
  logic [AW-1:0] a_addr_3, b_addr_3;
  logic [DW-1:0] a_wdata_3, b_wdata_3;
  logic          a_gnt_3, a_rvalid_3, a_err_3;
  logic          b_gnt_3, b_rvalid_3, b_err_3;
  logic [DW-1:0] a_rdata_3, b_rdata_3;
  logic          mem_rd_3, mem_wr_3, busy_3;
  logic [2:0]    mem_nb_3;
  logic [AW-1:0] mem_addr_3;
  logic [DW-1:0] mem_wdata_3, mem_rdata_3;

  dmem_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_nb(a_nb), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_nb(b_nb), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_nb(mem_nb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(3)) u3 (
    .clk(clk), .rst_n(rst_n_3),
    .a_req(a_req_3), .a_we(a_we_3), .a_nb(a_nb_3), .a_addr(a_addr_3),
    .a_wdata(a_wdata_3), .a_gnt(a_gnt_3), .a_rvalid(a_rvalid_3),
    .a_rdata(a_rdata_3), .a_err(a_err_3),
    .b_req(b_req_3), .b_we(b_we_3), .b_nb(b_nb_3), .b_addr(b_addr_3),
    .b_wdata(b_wdata_3), .b_gnt(b_gnt_3), .b_rvalid(b_rvalid_3),
    .b_rdata(b_rdata_3), .b_err(b_err_3),
    .mem_rd(mem_rd_3), .mem_wr(mem_wr_3), .mem_nb(mem_nb_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  logic [DW-1:0] mem [0:15];
  assign mem_rdata   = mem_rd ? mem[mem_addr[5:2]] : '0;
  assign mem_rdata_3 = mem_rd_3 ? 32'h5A5A_0003 : '0;
  always @(posedge clk) if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;

  int both_hi   = 0;
  int stray_stb = 0;
  always @(negedge clk) begin
    if (mem_rd && mem_wr) both_hi++;
    if ((mem_rd || mem_wr) && (!busy || a_rvalid || b_rvalid))
      stray_stb++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_3 = 1'b0;
    tick(); tick();
    checks++;
    if ({a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b expected 000000",
        {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err});
    end
    checks++;
    if ({mem_rd, mem_wr, busy} !== 3'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || mem_nb !== 3'b0 || a_rdata !== '0) begin
      errors++;
      $display("FAIL reset_mem: rd/wr/busy=%b addr=%h expected 000 0",
        {mem_rd, mem_wr, busy}, mem_addr);
    end
    rst_n = 1'b1; rst_n_3 = 1'b1;
    tick();
  endtask

  task automatic test_store();
    int wr_n, lat;
    bit seen;
    a_req = 1; a_we = 1; a_nb = 3'b010;
    a_addr = 32'h8; a_wdata = 32'h1234ABCD;
    tick();
    checks++;
    if ({a_gnt, mem_wr, mem_rd, a_rvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL store_gnt: gnt/wr/rd/rv=%b expected 1100",
        {a_gnt, mem_wr, mem_rd, a_rvalid});
    end
    checks++;
    if (mem_addr !== 32'h8 || mem_wdata !== 32'h1234ABCD ||
        mem_nb !== 3'b010) begin
      errors++;
      $display("FAIL store_bus: addr=%h wd=%h nb=%b expected 8 1234abcd 010",
        mem_addr, mem_wdata, mem_nb);
    end
    a_req = 0;
    wr_n = 1; lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      tick(); lat++;
      if (a_rvalid) seen = 1;
      else if (mem_wr) wr_n++;
    end
    checks++;
    if (lat != ACC || wr_n != ACC) begin
      errors++;
      $display("FAIL store_timing: lat=%0d wr_cycles=%0d expected %0d %0d",
        lat, wr_n, ACC, ACC);
    end
    checks++;
    if (a_rdata !== '0 || a_err !== 0 || mem_wr !== 0 ||
        mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL store_resp: rdata=%h err=%b wr=%b addr=%h expected 0 0 0 8",
        a_rdata, a_err, mem_wr, mem_addr);
    end
    tick();
    checks++;
    if (busy !== 0 || a_rvalid !== 0) begin
      errors++;
      $display("FAIL store_idle: busy=%b rv=%b expected 0 0", busy, a_rvalid);
    end
  endtask

  task automatic test_load();
    int lat;
    bit seen;
    a_req = 1; a_we = 0; a_nb = 3'b010; a_addr = 32'h8;
    tick();
    checks++;
    if ({a_gnt, mem_rd, mem_wr, a_rvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL load_gnt: gnt/rd/wr/rv=%b expected 1100",
        {a_gnt, mem_rd, mem_wr, a_rvalid});
    end
    a_req = 0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      tick(); lat++;
      if (a_rvalid) seen = 1;
    end
    checks++;
    if (lat != ACC) begin
      errors++;
      $display("FAIL load_latency: edges=%0d expected %0d", lat, ACC);
    end
    checks++;
    if (a_rdata !== 32'h1234ABCD || a_err !== 0 || mem_rd !== 0) begin
      errors++;
      $display("FAIL load_data: rdata=%h err=%b rd=%b expected 1234abcd 0 0",
        a_rdata, a_err, mem_rd);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int n, t, last, gap_bad, both_gnt;
    logic [3:0] seq;
    rst_n = 0; tick(); rst_n = 1;
    a_req = 1; a_we = 0; a_nb = 3'b010; a_addr = 32'h10;
    b_req = 1; b_we = 1; b_nb = 3'b010; b_addr = 32'h20;
    b_wdata = 32'hB0B0_0001;
    n = 0; t = 0; last = 0; gap_bad = 0; both_gnt = 0; seq = '0;
    while (n < 4 && t < 60) begin
      tick(); t++;
      if (a_gnt && b_gnt) both_gnt++;
      if (a_gnt || b_gnt) begin
        seq[n] = b_gnt;
        if (n > 0 && (t - last) != ACC + 2) gap_bad++;
        last = t; n++;
      end
    end
    a_req = 0; b_req = 0;
    checks++;
    if (n != 4 || seq !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order: grants=%0d seq=%b expected 4 1010", n, seq);
    end
    checks++;
    if (gap_bad != 0 || both_gnt != 0) begin
      errors++;
      $display("FAIL rr_spacing: bad_gaps=%0d dual_gnt=%0d expected 0 0",
        gap_bad, both_gnt);
    end
    t = 0;
    while (busy && t < 20) begin tick(); t++; end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL rr_drain: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_wait();
    int t, ta, tb;
    a_req = 1; a_we = 1; a_nb = 3'b010;
    a_addr = 32'hC; a_wdata = 32'h0C0C_0C0C;
    tick();
    checks++;
    if (a_gnt !== 1) begin
      errors++;
      $display("FAIL wait_agnt: gnt=%b expected 1", a_gnt);
    end
    a_req = 0;
    b_req = 1; b_we = 0; b_nb = 3'b010; b_addr = 32'hC;
    t = 0; ta = -1; tb = -1;
    while (tb < 0 && t < 20) begin
      tick(); t++;
      if (a_rvalid) ta = t;
      if (b_gnt) tb = t;
    end
    b_req = 0;
    checks++;
    if (ta != ACC || tb != ACC + 2) begin
      errors++;
      $display("FAIL wait_order: a_rvalid@%0d b_gnt@%0d expected %0d %0d",
        ta, tb, ACC, ACC + 2);
    end
    t = 0;
    while (!b_rvalid && t < 20) begin tick(); t++; end
    checks++;
    if (b_rvalid !== 1 || b_rdata !== 32'h0C0C_0C0C || b_err !== 0) begin
      errors++;
      $display("FAIL wait_bdata: rv=%b rdata=%h err=%b expected 1 0c0c0c0c 0",
        b_rvalid, b_rdata, b_err);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int t, rd_n, lat;
    bit seen;
    a_req_3 = 1; a_we_3 = 0; a_nb_3 = 3'b010; a_addr_3 = 32'h40;
    tick();
    checks++;
    if (a_gnt_3 !== 1 || mem_rd_3 !== 1) begin
      errors++;
      $display("FAIL rst_mid_gnt: gnt=%b rd=%b expected 1 1", a_gnt_3, mem_rd_3);
    end
    a_req_3 = 0;
    tick();
    rst_n_3 = 0;
    tick();
    checks++;
    if (mem_rd_3 !== 0 || mem_wr_3 !== 0 || busy_3 !== 0 ||
        a_rvalid_3 !== 0) begin
      errors++;
      $display("FAIL rst_mid_abort: rd=%b wr=%b busy=%b rv=%b expected 0 0 0 0",
        mem_rd_3, mem_wr_3, busy_3, a_rvalid_3);
    end
    rst_n_3 = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_rvalid_3 || busy_3) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_quiet: late activity=%b expected 0", seen);
    end
    a_req_3 = 1; a_addr_3 = 32'h44;
    tick();
    a_req_3 = 0;
    rd_n = mem_rd_3 ? 1 : 0;
    lat = 0; seen = 0; t = 0;
    while (!seen && t < 20) begin
      tick(); t++;
      if (a_rvalid_3) begin seen = 1; lat = t; end
      else if (mem_rd_3) rd_n++;
    end
    checks++;
    if (lat != 3 || rd_n != 3 || a_rdata_3 !== 32'h5A5A_0003) begin
      errors++;
      $display("FAIL rst_mid_next: lat=%0d rd_cycles=%0d rdata=%h expected 3 3 5a5a0003",
        lat, rd_n, a_rdata_3);
    end
  endtask

  task automatic test_misalign();
    int wr_n, lat, exp_wr, exp_lat;
    bit seen, exp_err;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    exp_wr = 0; exp_lat = 1; exp_err = 1;
`else
    exp_wr = ACC; exp_lat = ACC; exp_err = 0;
`endif
    a_req = 1; a_we = 1; a_nb = 3'b010;
    a_addr = 32'h6; a_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (a_gnt !== 1) begin
      errors++;
      $display("FAIL misalign_gnt: gnt=%b expected 1", a_gnt);
    end
    a_req = 0;
    wr_n = mem_wr ? 1 : 0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      tick(); lat++;
      if (a_rvalid) seen = 1;
      else if (mem_wr) wr_n++;
    end
    checks++;
    if (lat != exp_lat || wr_n != exp_wr) begin
      errors++;
      $display("FAIL misalign_timing: lat=%0d wr_cycles=%0d expected %0d %0d",
        lat, wr_n, exp_lat, exp_wr);
    end
    checks++;
    if (a_err !== exp_err || a_rdata !== '0) begin
      errors++;
      $display("FAIL misalign_resp: err=%b rdata=%h expected %b 0",
        a_err, a_rdata, exp_err);
    end
    tick(); tick();
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (both_hi != 0 || stray_stb != 0) begin
      errors++;
      $display("FAIL strobe_rules: both_high=%0d outside_access=%0d expected 0 0",
        both_hi, stray_stb);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    a_req = 0; a_we = 0; a_nb = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_nb = '0; b_addr = '0; b_wdata = '0;
    a_req_3 = 0; a_we_3 = 0; a_nb_3 = '0; a_addr_3 = '0; a_wdata_3 = '0;
    b_req_3 = 0; b_we_3 = 0; b_nb_3 = '0; b_addr_3 = '0; b_wdata_3 = '0;
    test_reset();
    test_store();
    test_load();
    test_round_robin();
    test_wait();
    test_reset_mid();
    test_misalign();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
